// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with internal binary pointers (wrap bit in MSB),
// registered read data, full/empty/almost flags and occupancy count.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_i            synchronous, active-high reset
//   wr_en_i          write request; accepted when not full
//   wr_data_i        write data, sampled on an accepted write
//   rd_en_i          read request; accepted when not empty
//   rd_data_o        registered read data, one cycle after an accepted read
//   rd_valid_o       rd_data_o holds a newly read entry this cycle
//   full_o           count == DEPTH
//   empty_o          count == 0
//   almost_full_o    count >= AF_THRESH
//   almost_empty_o   count <= AE_THRESH
//   count_o          entries held, 0..DEPTH
//   overflow_o       sticky: write attempted while full (FIFO_ERR_FLAGS_EN only, else 0)
//   underflow_o      sticky: read attempted while empty (FIFO_ERR_FLAGS_EN only, else 0)
//
// Build option: define FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.

module param_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    localparam logic [PTR_W-1:0] AfLevel = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AeLevel = PTR_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic full, empty;
    logic wr_accept, rd_accept;
    logic [PTR_W-1:0] count;

    // Flags come straight from the registered pointers; same wrap bit means equal
    // pointers are empty, differing wrap bit with equal index means full.
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    end

    // Acceptance uses pre-edge flags, so no read fall-through on empty and no
    // write-through on full when both requests arrive together.
    assign wr_accept = wr_en_i && !full;
    assign rd_accept = rd_en_i && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rd_data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is not reset; writes during reset are suppressed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_accept) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wr_en_i && full);
        underflow_d = underflow_q || (rd_en_i && empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count >= AfLevel);
    assign almost_empty_o = (count <= AeLevel);
    assign count_o        = count;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Testbench for param_sync_fifo (DATA_WIDTH=8, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=2).
// A queue-based reference model is checked every cycle; a vector table covers
// reset/fill/overflow/drain, and hand-written sequences cover wrap, simultaneous
// requests, mid-operation reset and randomized traffic.

module tb_param_sync_fifo;

    localparam int Depth = 8;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    param_sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .rd_en_i        (rd_en),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .count_o        (count),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a plain queue.
    logic [7:0] m_q[$];
    logic [7:0] m_rdata = 8'h00;
    bit         m_rv    = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         m_unf   = 1'b0;

    typedef struct {
        bit         rst;
        bit         wr;
        logic [7:0] wd;
        bit         rd;
        int         cnt;
        bit         emp;
        bit         ful;
        bit         af;
        bit         ae;
        bit         rv;
        logic [7:0] rdat;
        bit         ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit w, input logic [7:0] d, input bit rd);
        int  n;
        bit  was_full, was_empty;
        n         = m_q.size();
        was_full  = (n == Depth);
        was_empty = (n == 0);
        if (r) begin
            m_q.delete();
            m_rdata = 8'h00;
            m_rv    = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            if (rd && !was_empty) begin
                m_rdata = m_q.pop_front();
                m_rv    = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
            if (w && !was_full) m_q.push_back(d);
            if (ErrEn && w && was_full) m_ovf = 1'b1;
            if (ErrEn && rd && was_empty) m_unf = 1'b1;
        end
    endtask

    task automatic compare_model();
        int n;
        n = m_q.size();
        chk("m_count", 32'(count), 32'(n));
        chk("m_empty", 32'(empty), 32'(n == 0));
        chk("m_full", 32'(full), 32'(n == Depth));
        chk("m_almost_full", 32'(almost_full), 32'(n >= 6));
        chk("m_almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("m_rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("m_rd_data", 32'(rd_data), 32'(m_rdata));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rd);
        @(negedge clk);
        rst     = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = rd;
        @(posedge clk);
        model_update(r, w, d, rd);
        #1;
        compare_model();
    endtask

    initial begin
        int wp;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;

        // Vector table: reset, fill, overflow attempt, drain.
        for (int i = 0; i < 2; i++)
            vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                             8'h00, 1'b0});
        for (int i = 0; i < 8; i++) begin
            int c;
            c = i + 1;
            vecs.push_back('{1'b0, 1'b1, 8'(8'h10 + i), 1'b0, c, 1'b0, (c == 8), (c >= 6),
                             (c <= 2), 1'b0, 8'h00, 1'b0});
        end
        vecs.push_back('{1'b0, 1'b1, 8'hAA, 1'b0, 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00,
                         ErrEn});
        for (int i = 0; i < 8; i++) begin
            int c;
            c = 7 - i;
            vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, c, (c == 0), 1'b0, (c >= 6), (c <= 2),
                             1'b1, 8'(8'h10 + i), ErrEn});
        end

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd);
            chk("t_count", 32'(count), 32'(vecs[i].cnt));
            chk("t_empty", 32'(empty), 32'(vecs[i].emp));
            chk("t_full", 32'(full), 32'(vecs[i].ful));
            chk("t_almost_full", 32'(almost_full), 32'(vecs[i].af));
            chk("t_almost_empty", 32'(almost_empty), 32'(vecs[i].ae));
            chk("t_rd_valid", 32'(rd_valid), 32'(vecs[i].rv));
            chk("t_rd_data", 32'(rd_data), 32'(vecs[i].rdat));
            chk("t_overflow", 32'(overflow), 32'(vecs[i].ovf));
        end

        // Wrap: 12 write/read pairs carry both pointers past the end of storage.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("wrap_data", 32'(rd_data), 32'(8'h20 + i));
            chk("wrap_valid", 32'(rd_valid), 32'd1);
        end

        // Simultaneous at full: read wins, write dropped.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        chk("sim_full_count", 32'(count), 32'd7);
        chk("sim_full_data", 32'(rd_data), 32'h40);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("sim_full_drain", 32'(rd_data), 32'(8'h41 + i));
        end

        // Simultaneous at empty: write wins, no fall-through.
        step(1'b0, 1'b1, 8'h55, 1'b1);
        chk("sim_empty_count", 32'(count), 32'd1);
        chk("sim_empty_valid", 32'(rd_valid), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("sim_empty_data", 32'(rd_data), 32'h55);

        // Simultaneous at count 4: count holds, order preserved.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b1, 8'h64, 1'b1);
        chk("sim_mid_count", 32'(count), 32'd4);
        chk("sim_mid_data", 32'(rd_data), 32'h60);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("sim_mid_order", 32'(rd_data), 32'(8'h61 + i));
        end

        // Mid-operation reset at count 5 with both requests asserted.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 800; i++) begin
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < wp),
                 8'($urandom),
                 ($urandom_range(0, 99) < (100 - wp)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
